// File: rtl/power3_pkg.sv
// ----------------------------------------------------------------------------
// power3_pkg
// Shared types and constants for the power-of-3 sequencer.
//   state_e : sequencer FSM states
//   GuardW  : extra high-order bits kept by the checker when it computes prev*3
// ----------------------------------------------------------------------------
package power3_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StFin
    } state_e;

    // 3*prev can never need more than two extra bits.
    localparam int unsigned GuardW = 2;

endpackage

// File: rtl/power3_checker.sv
// ----------------------------------------------------------------------------
// power3_checker
// Combinational check of one captured generator term against the previous one.
// Ports:
//   prev_i     : previously captured term
//   gen_data_i : term about to be captured
//   first_i    : high when the term is index 0 (must equal 1)
//   ovf_hit_o  : prev*3 does not fit in data_size bits (never for index 0)
//   mis_hit_o  : gen_data differs from the expected value
// ----------------------------------------------------------------------------
module power3_checker
    import power3_pkg::*;
#(
    parameter int unsigned data_size = 32
) (
    input  logic [data_size-1:0] prev_i,
    input  logic [data_size-1:0] gen_data_i,
    input  logic                 first_i,
    output logic                 ovf_hit_o,
    output logic                 mis_hit_o
);

    logic [data_size+GuardW-1:0] p3;

    always_comb begin
        p3 = {{GuardW{1'b0}}, prev_i} * (data_size + GuardW)'(3);
        ovf_hit_o = !first_i && (p3[data_size+GuardW-1:data_size] != '0);
        if (first_i) begin
            mis_hit_o = (gen_data_i != data_size'(1));
        end else begin
            mis_hit_o = (gen_data_i != p3[data_size-1:0]);
        end
    end

endmodule

// File: rtl/power3_sequencer.sv
// ----------------------------------------------------------------------------
// power3_sequencer
// Runs the power-of-3 generator for one run of N terms and streams each term
// to a consumer through a one-entry valid/ready output register.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, count          : run request and number of terms (sampled in idle)
//   abort                 : terminate the current run
//   busy, done            : not idle / one-cycle end-of-run pulse
//   gen_rst, gen_enable   : generator clear / advance
//   gen_data              : generator output
//   out_data, out_index   : captured term and its exponent
//   out_valid, out_ready  : output handshake
//   overflow, mismatch    : sticky checker flags, cleared by an accepted start
// ----------------------------------------------------------------------------
module power3_sequencer
    import power3_pkg::*;
#(
    parameter int unsigned data_size = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     count,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 gen_rst,
    output logic                 gen_enable,
    input  logic [data_size-1:0] gen_data,
    output logic [data_size-1:0] out_data,
    output logic [CNT_W-1:0]     out_index,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 mismatch
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [CNT_W-1:0]       out_index_q, out_index_d;
    logic [data_size-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   mismatch_q, mismatch_d;
    logic                   gen_rst_q, gen_rst_d;
    logic                   capture;
    logic                   ovf_hit, mis_hit;

    power3_checker #(
        .data_size (data_size)
    ) u_checker (
        .prev_i     (out_data_q),
        .gen_data_i (gen_data),
        .first_i    (issued_q == '0),
        .ovf_hit_o  (ovf_hit),
        .mis_hit_o  (mis_hit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        issued_d    = issued_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        mismatch_d  = mismatch_q;
        capture     = 1'b0;
        gen_enable  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != '0) begin
                        state_d    = StClear;
                        count_d    = count;
                        issued_d   = '0;
                        overflow_d = 1'b0;
                        mismatch_d = 1'b0;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StClear: begin
                state_d = abort ? StFin : StRun;
            end
            StRun: begin
                if (abort) begin
                    // Abort wins over a capture in the same cycle.
                    state_d     = StFin;
                    out_valid_d = 1'b0;
                end else begin
                    // The register is free when empty or being drained this edge.
                    capture    = !out_valid_q || out_ready;
                    gen_enable = capture;
                    if (capture) begin
                        out_data_d  = gen_data;
                        out_index_d = issued_q;
                        out_valid_d = 1'b1;
                        issued_d    = issued_q + 1'b1;
                        if (ovf_hit) overflow_d = 1'b1;
                        if (mis_hit) mismatch_d = 1'b1;
                        if (issued_q == count_q - 1'b1) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (abort || out_ready) begin
                    state_d     = StFin;
                    out_valid_d = 1'b0;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so that it is high for exactly the one CLEAR cycle.
        gen_rst_d = (state_d == StClear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            issued_q    <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            gen_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            mismatch_q  <= mismatch_d;
            gen_rst_q   <= gen_rst_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign gen_rst   = gen_rst_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_power3_sequencer.sv
// ----------------------------------------------------------------------------
// tb_power3_sequencer
// Scoreboard bench: each run pushes its expected term stream into a queue and
// a negedge monitor pops/compares on every transfer. A behavioural generator
// model drives gen_data, optionally corrupting the index-2 term.
// ----------------------------------------------------------------------------
module tb_power3_sequencer;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, gen_rst, gen_enable, out_valid, overflow, mismatch;
    logic [DW-1:0] gen_data, out_data, pow;
    logic [CW-1:0] out_index;
    logic          corrupt = 1'b0;

    power3_sequencer #(
        .data_size (DW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .count      (count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .gen_rst    (gen_rst),
        .gen_enable (gen_enable),
        .gen_data   (gen_data),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // Generator model.
    always @(posedge clk) begin
        if (gen_rst) pow <= 32'd1;
        else if (gen_enable) pow <= pow * 32'd3;
    end
    assign gen_data = (corrupt && pow == 32'd9) ? 32'd10 : pow;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] idx;
    } term_t;

    term_t         sb_q[$];
    logic [DW-1:0] run_terms[$];
    int            errors = 0;
    int            checks = 0;
    int            force_low = 0;
    int            stall_idx = -1;
    bit            rand_ready = 1'b0;
    int            gen_rst_seen, valid_seen;
    longint        last_xfer_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Consumer ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (force_low > 0) begin
                out_ready = 1'b0;
                if (out_valid) force_low--;
            end else if (stall_idx >= 0 && out_valid && int'(out_index) == stall_idx) begin
                out_ready = 1'b0;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer.
    initial begin
        bit    prev_stall = 1'b0;
        term_t prev_t;
        term_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid) valid_seen++;
                if (gen_rst) gen_rst_seen++;
                if (out_valid && out_ready) begin
                    last_xfer_t = $time;
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_transfer");
                    end else begin
                        t = sb_q.pop_front();
                        chk("xfer_data", out_data, t.data);
                        chk("xfer_index", out_index, t.idx);
                    end
                end
                if (out_valid && !out_ready) chk("stall_gen_enable", gen_enable, 0);
                if (prev_stall && out_valid) begin
                    chk("hold_data", out_data, prev_t.data);
                    chk("hold_index", out_index, prev_t.idx);
                end
                prev_stall = out_valid && !out_ready;
                prev_t     = '{data: out_data, idx: out_index};
            end
        end
    end

    task automatic start_run(input int n, input bit corr);
        logic [DW-1:0] t = 32'd1;
        logic [DW-1:0] v;
        run_terms.delete();
        corrupt = corr;
        for (int k = 0; k < n; k++) begin
            if (k > 0) t = t * 32'd3;
            v = (corr && k == 2) ? 32'd10 : t;
            run_terms.push_back(v);
            sb_q.push_back('{data: v, idx: CW'(k)});
        end
        @(posedge clk);
        #2;
        gen_rst_seen = 0;
        valid_seen   = 0;
        start = 1'b1;
        count = CW'(n);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Flags implied by the streamed terms 0..last.
    task automatic model_flags(input int last, output bit ovf, output bit mis);
        logic [63:0] p;
        ovf = 1'b0;
        mis = (run_terms[0] != 32'd1);
        for (int k = 1; k <= last; k++) begin
            p = {32'd0, run_terms[k-1]} * 64'd3;
            if (p[63:32] != 32'd0) ovf = 1'b1;
            if (run_terms[k] != p[31:0]) mis = 1'b1;
        end
    endtask

    task automatic wait_index(input int idx);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (out_valid && int'(out_index) == idx) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_index_timeout");
    endtask

    // Stall on index idx, then abort while the term is pending.
    task automatic abort_at(input int idx);
        stall_idx = idx;
        wait_index(idx);
        abort = 1'b1;
    endtask

    task automatic finish_run(input int n, input int abort_idx);
        bit ok = 1'b0;
        bit ovf, mis;
        int last;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            abort = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        stall_idx = -1;
        if (!ok) begin
            fail_now("done_timeout");
        end else begin
            chk("busy_at_done", busy, 1);
            chk("valid_at_done", out_valid, 0);
            if (n == 0) begin
                chk("zero_gen_rst", gen_rst_seen, 0);
                chk("zero_valid", valid_seen, 0);
            end else begin
                chk("gen_rst_cycles", gen_rst_seen, 1);
                last = (abort_idx >= 0) ? abort_idx : n - 1;
                model_flags(last, ovf, mis);
                chk("overflow", overflow, ovf);
                chk("mismatch", mismatch, mis);
                if (abort_idx < 0) chk("done_after_last_xfer", ($time - last_xfer_t) / 10, 1);
            end
            chk("left_in_sb", sb_q.size(), (abort_idx >= 0) ? n - abort_idx : 0);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
        end
        sb_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, lat;
        bit ok;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gen_rst", gen_rst, 1);
        chk("rst_gen_enable", gen_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // count=4, ready high: 1,3,9,27 from cycle 3.
        start_run(4, 0);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            lat++;
        end
        if (!ok) fail_now("first_valid_timeout");
        else chk("first_valid_latency", lat, 3);
        finish_run(4, -1);

        // count=3 with a 5-cycle stall on the first term.
        force_low = 5;
        start_run(3, 0);
        finish_run(3, -1);

        // count=22: overflow appears exactly at index 21.
        start_run(22, 0);
        wait_index(20);
        chk("idx20_data", out_data, 64'd3486784401);
        chk("idx20_overflow", overflow, 0);
        wait_index(21);
        chk("idx21_data", out_data, 64'd1870418611);
        chk("idx21_overflow", overflow, 1);
        finish_run(22, -1);
        repeat (3) @(negedge clk);
        chk("overflow_sticky", overflow, 1);

        // count=0.
        start_run(0, 0);
        finish_run(0, -1);

        // count=10 with an ignored start while busy, abort at index 4.
        start_run(10, 0);
        @(posedge clk);
        #2;
        start = 1'b1;
        count = 8'd3;
        @(posedge clk);
        #2;
        start = 1'b0;
        abort_at(4);
        finish_run(10, 4);
        start_run(2, 0);
        finish_run(2, -1);

        // Corrupted generator at index 2.
        start_run(5, 1);
        finish_run(5, -1);

        // Async reset mid-run.
        start_run(30, 0);
        wait_index(25);
        chk("pre_rst_overflow", overflow, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_index", out_index, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_gen_rst", gen_rst, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Longest legal run.
        start_run(255, 0);
        finish_run(255, -1);

        // Randomized runs with random backpressure and occasional aborts.
        rand_ready = 1'b1;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 40);
            a = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) a = $urandom_range(0, n - 1);
            start_run(n, $urandom_range(0, 5) == 0);
            if (a >= 0) abort_at(a);
            finish_run(n, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/power3_sequencer.md
Name: power3_sequencer

Overview:
- Controller that sequences the power-of-3 generator for one run of N terms.
- Drives the generator's reset and enable, captures each term into a one-entry output register, and streams terms to a consumer with valid/ready backpressure.
- Checks the arithmetic chain and flags overflow. It sits between the generator datapath and any downstream consumer or host.

Parameters:
- data_size, 32, width of generator output and streamed term.
- CNT_W, 8, width of term-count request and term index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- count  in  CNT_W  number of terms to stream; sampled with start.
- abort  in  1  terminate the current run.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes or aborts.
- gen_rst  out  1  generator clear.
- gen_enable  out  1  generator advance.
- gen_data  in  data_size  generator power_of_3 output.
- out_data  out  data_size  captured term.
- out_index  out  CNT_W  exponent k of out_data.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- overflow  out  1  sticky: some streamed term exceeded 2^data_size-1.
- mismatch  out  1  sticky: gen_data differs from 3*previous term (mod 2^data_size).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Asserting rst forces all of the following immediately, and the cleared state holds until the first edge after release:
  - state=IDLE;
  - busy, done, gen_enable, out_valid, overflow, mismatch = 0;
  - out_data, out_index = 0;
  - gen_rst = 1.
- Generator contract:
  - gen_rst high at an edge sets power_of_3 = 1.
  - gen_enable high at an edge sets power_of_3 = 3*power_of_3 mod 2^data_size.
  - The new value is visible the cycle after the edge.
- States: IDLE, CLEAR, RUN, DRAIN, FIN.
- IDLE:
  - gen_rst = 0, gen_enable = 0.
  - start=1 with count>0 -> CLEAR. Also latch count, clear overflow and mismatch, set issued=0.
  - start=1 with count=0 -> FIN. No terms are streamed.
- CLEAR:
  - gen_rst = 1 for exactly one cycle, then -> RUN.
- RUN:
  - Capture condition: capture = !out_valid || out_ready.
  - gen_enable = capture; it is combinational from state and the handshake.
  - On capture: out_data <= gen_data, out_index <= issued, out_valid <= 1, issued <= issued+1.
  - On the capture with issued == count-1 -> DRAIN.
  - While out_valid && !out_ready: out_data and out_index are held stable, and gen_enable = 0.
- DRAIN:
  - gen_enable = 0.
  - On out_ready: out_valid <= 0 and go -> FIN.
- FIN:
  - done = 1 for one cycle, then -> IDLE.
- Handshake: a transfer occurs at an edge where out_valid && out_ready. out_valid never drops without a transfer, except on abort or rst.
- Latency: start sampled at edge 0 -> gen_rst high during cycle 1 -> first capture at edge 2 -> out_valid high from cycle 3. With out_ready held high, one term is streamed per cycle.
- Checker (applies to each capture with index k >= 1; prev = out_data):
  - Compute p3 = {2'b00, prev} * 3 at data_size+2 bits.
  - If the upper 2 bits of p3 are nonzero, set overflow.
  - If gen_data != p3[data_size-1:0], set mismatch.
  - The k = 0 capture must equal 1; otherwise set mismatch.
  - Flags are sticky until the next accepted start.
- abort:
  - In CLEAR, RUN or DRAIN: -> FIN next edge, out_valid <= 0, pending term dropped.
  - Flags are kept.
  - Ignored in IDLE and FIN.
- Simultaneous events: rst overrides everything. abort overrides capture in the same cycle. start while busy is ignored.
- Boundary: count = 2^CNT_W-1 is legal; issued is CNT_W bits wide and never wraps within a run.

Decomposition:
- Shared package power3_pkg: state enum (IDLE, CLEAR, RUN, DRAIN, FIN) and a localparam for the 2-bit checker guard width.
- One sub-module, power3_checker: combinational prev*3 compare producing ovf_hit and mis_hit. The FSM and sticky flags stay in the top.

Test Plan:
- count=4, out_ready=1: out_data 1,3,9,27 with out_index 0..3 on consecutive cycles from cycle 3; done pulses one cycle after the last transfer; overflow=0, mismatch=0.
- count=3, out_ready low for 5 cycles after the first out_valid: out_data stays 1 and gen_enable=0 throughout; then 3 and 9 follow; exactly 3 transfers.
- count=22, out_ready=1: index 20 gives 3486784401 with overflow=0; index 21 gives 1870418611 with overflow=1, sticky until the next start.
- count=0: busy for one cycle, done pulse, no out_valid, gen_rst never asserted.
- count=10, abort at index 4 while stalled: out_valid drops, done pulses, FSM returns to IDLE; a following start with count=2 streams 1,3.
- Bench generator model returns 10 instead of 9 at index 2: mismatch=1, overflow=0. Async rst asserted mid-run clears all outputs within the same cycle.
